// File: rtl/iram_mp_loader.sv
// Shared instruction RAM: NUM_CORES round-robin fetch ports, 1-cycle read,
// plus a word-serial program-load port that holds off fetches while loading.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   fetch_req/fetch_addr          per-core request and packed addresses
//   fetch_gnt                     one-hot grant (combinational)
//   fetch_valid/fetch_data        one-hot return, shared data bus
//   fetch_err                     sticky out-of-range fetch flag
//   load_start/wr/data/end        program-load controls
//   load_busy/done/count/ovf      program-load status
module iram_mp_loader #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int NUM_CORES = 4,
  parameter     INIT_FILE = ""
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        fetch_req,
  input  logic [NUM_CORES*ADDR_W-1:0] fetch_addr,
  output logic [NUM_CORES-1:0]        fetch_gnt,
  output logic [NUM_CORES-1:0]        fetch_valid,
  output logic [DATA_W-1:0]           fetch_data,
  output logic                        fetch_err,
  input  logic                        load_start,
  input  logic                        load_wr,
  input  logic [DATA_W-1:0]           load_data,
  input  logic                        load_end,
  output logic                        load_busy,
  output logic                        load_done,
  output logic [ADDR_W:0]             load_count,
  output logic                        load_ovf
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RR_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [RR_W-1:0]  LAST_C  = RR_W'(NUM_CORES - 1);

  typedef enum logic {
    IDLE,
    LOAD
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] ram [DEPTH];

  logic [CNT_W-1:0]     ptr_q;
  logic [RR_W-1:0]      rr_q, rr_d;
  logic [NUM_CORES-1:0] gnt;
  logic                 gnt_any;
  logic [RR_W-1:0]      gnt_idx;
  logic [ADDR_W-1:0]    sel_addr;
  logic                 sel_oob;
  logic                 restart;
  logic                 wr_ok;
  logic                 we;
  logic                 wr_drop;
  logic                 ovf_q;
  logic                 done_q;
  logic                 err_q;
  logic [NUM_CORES-1:0] valid_q;
  logic [DATA_W-1:0]    data_q;
  int                   c;

  // First requester at or after rr_q, wrapping; nothing while loading.
  // Gated by rst_n so the grant is quiet during reset as well.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_d    = rr_q;
    c       = 0;
    if (rst_n && state_q == IDLE) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        c = (int'(rr_q) + k) % NUM_CORES;
        if (!gnt_any && fetch_req[c]) begin
          gnt_any = 1'b1;
          gnt_idx = RR_W'(c);
          gnt[c]  = 1'b1;
        end
      end
    end
    if (gnt_any)
      rr_d = (gnt_idx == LAST_C) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    sel_addr = fetch_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    sel_oob  = {1'b0, sel_addr} >= DEPTH_C;
  end

  // load_end wins over a same-cycle load_start while loading.
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          restart = 1'b1;
        end
      end
      LOAD: begin
        if (load_end)
          state_d = IDLE;
        else if (load_start)
          restart = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    wr_ok   = (state_q == LOAD) && load_wr && !restart;
    we      = wr_ok && (ptr_q < DEPTH_C);
    wr_drop = wr_ok && !(ptr_q < DEPTH_C);
  end

  // Array has no reset: a partial image survives a reset.
  always_ff @(posedge clk) begin
    if (we)
      ram[ptr_q[IDX_W-1:0]] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      done_q  <= (state_q == LOAD) && load_end;
      valid_q <= gnt;
      if (restart) begin
        ptr_q <= '0;
        ovf_q <= 1'b0;
      end else if (we) begin
        ptr_q <= ptr_q + 1'b1;
      end else if (wr_drop) begin
        ovf_q <= 1'b1;
      end
      if (gnt_any) begin
        data_q <= sel_oob ? '0 : ram[sel_addr[IDX_W-1:0]];
        if (sel_oob)
          err_q <= 1'b1;
      end
    end
  end

  assign fetch_gnt   = gnt;
  assign fetch_valid = valid_q;
  assign fetch_data  = data_q;
  assign fetch_err   = err_q;
  assign load_busy   = (state_q == LOAD);
  assign load_done   = done_q;
  assign load_count  = ptr_q;
  assign load_ovf    = ovf_q;

endmodule

// File: tb/tb_iram_mp_loader.sv
// Scoreboard bench for iram_mp_loader (DEPTH=8, 4 cores).
// Driver predicts grants and pushes expected returns; monitor pops them.
module tb_iram_mp_loader;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int D  = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    fetch_req = '0;
  logic [N*AW-1:0] fetch_addr = '0;
  logic [N-1:0]    fetch_gnt;
  logic [N-1:0]    fetch_valid;
  logic [DW-1:0]   fetch_data;
  logic            fetch_err;
  logic            load_start = 1'b0;
  logic            load_wr = 1'b0;
  logic [DW-1:0]   load_data = '0;
  logic            load_end = 1'b0;
  logic            load_busy;
  logic            load_done;
  logic [AW:0]     load_count;
  logic            load_ovf;

  always #5 clk = ~clk;

  iram_mp_loader #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .NUM_CORES(N)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_valid(fetch_valid),
    .fetch_data(fetch_data), .fetch_err(fetch_err),
    .load_start(load_start), .load_wr(load_wr),
    .load_data(load_data), .load_end(load_end),
    .load_busy(load_busy), .load_done(load_done),
    .load_count(load_count), .load_ovf(load_ovf)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0]  v;
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  exp_t sbq[$];

  int          rr = 0;
  int          ptr = 0;
  bit          in_load = 0;
  bit          ovf = 0;
  bit          err = 0;
  bit          done = 0;
  logic [DW-1:0] mem [D];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid must match the oldest expected entry, on time.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fetch_valid != '0) begin
        if (sbq.size() == 0) begin
          check("unexpected_valid", 32'(fetch_valid), 32'(0));
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("valid", 32'(fetch_valid), 32'(e.v));
          check("data", 32'(fetch_data), 32'(e.d));
          check("latency", 32'(cyc), 32'(e.due));
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        check("missing_valid", 32'(fetch_valid), 32'(sbq[0].v));
        void'(sbq.pop_front());
      end
    end
  end

  // One clock: predict grant, push expectation, update load model,
  // then check status after the edge.
  task automatic tick();
    logic [N-1:0]  eg;
    logic [AW-1:0] a;
    exp_t          e;
    int            g;
    bit            rs;
    #1;
    eg = '0;
    g  = -1;
    if (!in_load) begin
      for (int k = 0; k < N; k++) begin
        int cc;
        cc = (rr + k) % N;
        if (g < 0 && fetch_req[cc]) g = cc;
      end
    end
    if (g >= 0) begin
      eg[g] = 1'b1;
      a     = fetch_addr[g*AW +: AW];
      e.v   = eg;
      e.d   = (a < D) ? mem[a[2:0]] : 16'h0;
      e.due = cyc + 1;
      sbq.push_back(e);
      rr = (g + 1) % N;
      if (a >= D) err = 1;
    end
    check("gnt", 32'(fetch_gnt), 32'(eg));
    done = 0;
    if (in_load) begin
      rs = load_start && !load_end;
      if (load_wr && !rs) begin
        if (ptr < D) begin
          mem[ptr] = load_data;
          ptr++;
        end else begin
          ovf = 1;
        end
      end
      if (rs) begin
        ptr = 0;
        ovf = 0;
      end
      if (load_end) begin
        in_load = 0;
        done    = 1;
      end
    end else if (load_start) begin
      in_load = 1;
      ptr     = 0;
      ovf     = 0;
    end
    @(posedge clk);
    #1;
    check("busy", 32'(load_busy), 32'(in_load));
    check("done", 32'(load_done), 32'(done));
    check("count", 32'(load_count), 32'(ptr));
    check("ovf", 32'(load_ovf), 32'(ovf));
    check("err", 32'(fetch_err), 32'(err));
  endtask

  task automatic setf(input logic [N-1:0] r,
                      input int a0, input int a1,
                      input int a2, input int a3);
    fetch_req  = r;
    fetch_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic lstart();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic lwr(input logic [DW-1:0] d);
    load_wr   = 1'b1;
    load_data = d;
    tick();
    load_wr   = 1'b0;
  endtask

  task automatic lend();
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with requests held to see the grant stay quiet.
    setf(4'b1111, 0, 1, 2, 3);
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(fetch_gnt), 32'(0));
    check("rst_valid", 32'(fetch_valid), 32'(0));
    check("rst_data", 32'(fetch_data), 32'(0));
    check("rst_busy", 32'(load_busy), 32'(0));
    check("rst_count", 32'(load_count), 32'(0));
    check("rst_err", 32'(fetch_err), 32'(0));
    setf(4'b0000, 0, 0, 0, 0);
    rst_n = 1'b1;

    // 1: load three words, core0 reads them back.
    lstart();
    lwr(16'h00A1);
    lwr(16'h00B2);
    lwr(16'h00C3);
    lend();
    for (int k = 0; k < 3; k++) begin
      setf(4'b0001, k, 0, 0, 0);
      tick();
    end
    setf(4'b0000, 0, 0, 0, 0);
    tick();
    tick();

    // 2: all cores request continuously.
    setf(4'b1111, 0, 1, 2, 0);
    repeat (8) tick();
    setf(4'b0000, 0, 0, 0, 0);
    tick();

    // 3: requests held across a reload.
    lstart();
    setf(4'b1111, 2, 1, 0, 2);
    lwr(16'h00A1);
    lwr(16'h00B2);
    lwr(16'h00C3);
    lend();
    tick();
    tick();
    setf(4'b0000, 0, 0, 0, 0);
    tick();
    tick();

    // 4: overflow, then restart clears it; start+end+wr together.
    lstart();
    for (int k = 0; k < 9; k++) lwr(16'(32'h1000 + k));
    lend();
    setf(4'b0100, 0, 0, 7, 0);
    tick();
    setf(4'b0000, 0, 0, 0, 0);
    tick();
    lstart();
    load_wr    = 1'b1;
    load_data  = 16'hBEEF;
    load_start = 1'b1;
    load_end   = 1'b1;
    tick();
    load_wr    = 1'b0;
    load_start = 1'b0;
    load_end   = 1'b0;
    tick();
    setf(4'b0001, 0, 0, 0, 0);
    tick();
    setf(4'b0010, 0, 7, 0, 0);
    tick();
    setf(4'b0000, 0, 0, 0, 0);
    tick();

    // 5: out-of-range fetch, sticky error.
    setf(4'b1000, 0, 0, 0, 1023);
    tick();
    setf(4'b0010, 0, 3, 0, 0);
    tick();
    setf(4'b0000, 0, 0, 0, 0);
    tick();
    tick();

    // 6: reset in the middle of a load.
    lstart();
    lwr(16'h5A5A);
    lwr(16'h6B6B);
    setf(4'b1111, 0, 1, 0, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(fetch_gnt), 32'(0));
    check("mid_rst_data", 32'(fetch_data), 32'(0));
    check("mid_rst_busy", 32'(load_busy), 32'(0));
    check("mid_rst_count", 32'(load_count), 32'(0));
    check("mid_rst_err", 32'(fetch_err), 32'(0));
    in_load = 0;
    ptr     = 0;
    ovf     = 0;
    err     = 0;
    rr      = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    setf(4'b0000, 0, 0, 0, 0);
    tick();
    tick();

    check("sb_empty", 32'(sbq.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
